// File: rtl/contador_mod_n_load.sv
// Up/down counter over [MIN, MAX] with synchronous clamped load, wrap or saturate at the limits,
// optional rising-edge qualification of up/down, and a registered one-cycle terminal-count pulse.
module contador_mod_n_load #(
   parameter int WIDTH    = 4,
   parameter int MIN      = 0,
   parameter int MAX      = 15,
   parameter int SATURATE = 0,
   parameter int EDGE     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             EN,
   input  logic             up,
   input  logic             down,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             dir
);

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_LOAD,
      OP_UP,
      OP_DOWN
   } op_t;

   localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   logic             up_q;
   logic             down_q;
   logic             up_req;
   logic             down_req;
   op_t              op;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] out_nxt;
   logic             tc_nxt;
   logic             dir_nxt;

   // Edge registers reset high so an input held across reset release is not seen as a rising edge.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         up_q   <= 1'b1;
         down_q <= 1'b1;
      end else begin
         up_q   <= up;
         down_q <= down;
      end
   end

   always_comb begin
      if (EDGE != 0) begin
         up_req   = up & ~up_q;
         down_req = down & ~down_q;
      end else begin
         up_req   = up;
         down_req = down;
      end
   end

   // Load beats any step; opposing requests in the same cycle cancel out.
   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      op = OP_HOLD;
      if (load) begin
         op = OP_LOAD;
      end else if (EN && up_req && !down_req) begin
         op = OP_UP;
      end else if (EN && down_req && !up_req) begin
         op = OP_DOWN;
      end
   end

   always_comb begin
      load_val = din;
      if (int'(din) > MAX) begin
         load_val = MAX_V;
      end else if (int'(din) < MIN) begin
         load_val = MIN_V;
      end
   end

   always_comb begin
      out_nxt = out;
      tc_nxt  = 1'b0;
      dir_nxt = dir;
      case (op)
         OP_LOAD: begin
            out_nxt = load_val;
         end
         OP_UP: begin
            dir_nxt = 1'b1;
            if (out == MAX_V) begin
               tc_nxt  = 1'b1;
               out_nxt = (SATURATE != 0) ? MAX_V : MIN_V;
            end else begin
               out_nxt = out + WIDTH'(1);
            end
         end
         OP_DOWN: begin
            dir_nxt = 1'b0;
            if (out == MIN_V) begin
               tc_nxt  = 1'b1;
               out_nxt = (SATURATE != 0) ? MIN_V : MAX_V;
            end else begin
               out_nxt = out - WIDTH'(1);
            end
         end
         default: begin
            out_nxt = out;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out <= MIN_V;
         tc  <= 1'b0;
         dir <= 1'b1;
      end else begin
         out <= out_nxt;
         tc  <= tc_nxt;
         dir <= dir_nxt;
      end
   end

endmodule

// File: tb/tb_contador_mod_n_load.sv
// Directed bench: four counter instances (default wrap, saturating 3..9, clamped load 2..12,
// level mode) driven by a linear sequence of steps with hand-computed expectations.
module tb_contador_mod_n_load;

   logic       clk = 1'b0;
   logic       rst;
   logic       en   [4];
   logic       up   [4];
   logic       dn   [4];
   logic       ld   [4];
   logic [3:0] din  [4];
   logic [3:0] q    [4];
   logic       tc   [4];
   logic       dir  [4];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   contador_mod_n_load u_def (
      .clk(clk), .rst(rst), .EN(en[0]), .up(up[0]), .down(dn[0]), .load(ld[0]),
      .din(din[0]), .out(q[0]), .tc(tc[0]), .dir(dir[0]));

   contador_mod_n_load #(.MIN(3), .MAX(9), .SATURATE(1)) u_sat (
      .clk(clk), .rst(rst), .EN(en[1]), .up(up[1]), .down(dn[1]), .load(ld[1]),
      .din(din[1]), .out(q[1]), .tc(tc[1]), .dir(dir[1]));

   contador_mod_n_load #(.MIN(2), .MAX(12)) u_clamp (
      .clk(clk), .rst(rst), .EN(en[2]), .up(up[2]), .down(dn[2]), .load(ld[2]),
      .din(din[2]), .out(q[2]), .tc(tc[2]), .dir(dir[2]));

   contador_mod_n_load #(.EDGE(0)) u_lvl (
      .clk(clk), .rst(rst), .EN(en[3]), .up(up[3]), .down(dn[3]), .load(ld[3]),
      .din(din[3]), .out(q[3]), .tc(tc[3]), .dir(dir[3]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int d, input logic [31:0] e_out,
                      input logic [31:0] e_tc, input logic [31:0] e_dir);
      checks++;
      assert ({28'd0, q[d]} === e_out) else begin
         failures++;
         $error("FAIL %s.out observed=%0d expected=%0d", tag, q[d], e_out);
      end
      checks++;
      assert ({31'd0, tc[d]} === e_tc) else begin
         failures++;
         $error("FAIL %s.tc observed=%0d expected=%0d", tag, tc[d], e_tc);
      end
      checks++;
      assert ({31'd0, dir[d]} === e_dir) else begin
         failures++;
         $error("FAIL %s.dir observed=%0d expected=%0d", tag, dir[d], e_dir);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         en[i] = 1'b0; up[i] = 1'b0; dn[i] = 1'b0; ld[i] = 1'b0; din[i] = 4'd0;
      end
      rst = 1'b1;
      up[0] = 1'b1;
      en[0] = 1'b1;
      #12;
      chk("rst_def", 0, 0, 0, 1);
      chk("rst_sat", 1, 3, 0, 1);
      chk("rst_clamp", 2, 2, 0, 1);
      chk("rst_lvl", 3, 0, 0, 1);
      tick();
      rst = 1'b0;

      // up held high across reset release must not step
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("hold_%0d", i), 0, 0, 0, 1);
      end
      up[0] = 1'b0; tick(); chk("hold_low", 0, 0, 0, 1);
      up[0] = 1'b1; tick(); chk("first_step", 0, 1, 0, 1);

      // wrap: steps 2..16 give 2..15 then 0 with tc only on 15->0
      for (int i = 2; i <= 16; i++) begin
         up[0] = 1'b0; tick();
         chk($sformatf("wrap_low_%0d", i), 0, i - 1, 0, 1);
         up[0] = 1'b1; tick();
         chk($sformatf("wrap_up_%0d", i), 0, i % 16, (i == 16) ? 1 : 0, 1);
      end

      // gating: edge while EN=0 is lost, not replayed
      up[0] = 1'b0; tick(); chk("gate_pre", 0, 0, 0, 1);
      en[0] = 1'b0; up[0] = 1'b1; tick(); chk("gate_off", 0, 0, 0, 1);
      tick(); chk("gate_off2", 0, 0, 0, 1);
      en[0] = 1'b1; tick(); chk("gate_no_replay", 0, 0, 0, 1);
      up[0] = 1'b0; tick();
      up[0] = 1'b1; dn[0] = 1'b1; tick(); chk("conflict", 0, 0, 0, 1);
      up[0] = 1'b0; dn[0] = 1'b0; tick();
      dn[0] = 1'b1; tick(); chk("wrap_down", 0, 15, 1, 0);
      dn[0] = 1'b0; tick(); chk("wrap_down_after", 0, 15, 0, 0);

      // saturate at MIN=3 and MAX=9
      en[1] = 1'b1;
      dn[1] = 1'b1; tick(); chk("sat_dn1", 1, 3, 1, 0);
      dn[1] = 1'b0; tick(); chk("sat_gap", 1, 3, 0, 0);
      dn[1] = 1'b1; tick(); chk("sat_dn2", 1, 3, 1, 0);
      dn[1] = 1'b0; ld[1] = 1'b1; din[1] = 4'd9; tick(); chk("sat_load9", 1, 9, 0, 0);
      ld[1] = 1'b0; up[1] = 1'b1; tick(); chk("sat_up_max", 1, 9, 1, 1);
      up[1] = 1'b0; tick(); chk("sat_up_after", 1, 9, 0, 1);

      // clamped load overrides a simultaneous up edge and keeps dir
      en[2] = 1'b1;
      dn[2] = 1'b1; tick(); chk("clamp_wrapdn", 2, 12, 1, 0);
      dn[2] = 1'b0; tick(); chk("clamp_idle", 2, 12, 0, 0);
      ld[2] = 1'b1; din[2] = 4'd14; up[2] = 1'b1; tick(); chk("clamp_hi", 2, 12, 0, 0);
      din[2] = 4'd1; tick(); chk("clamp_lo", 2, 2, 0, 0);
      din[2] = 4'd7; tick(); chk("load_mid", 2, 7, 0, 0);
      ld[2] = 1'b0; tick(); chk("load_no_step", 2, 7, 0, 0);

      // level mode from 13: 14, 15, 0, 1, 2
      ld[3] = 1'b1; din[3] = 4'd13; tick(); chk("lvl_load", 3, 13, 0, 1);
      ld[3] = 1'b0; en[3] = 1'b1; up[3] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("lvl_%0d", i), 3, (14 + i) % 16, (i == 2) ? 1 : 0, 1);
      end
      up[3] = 1'b0; tick(); chk("lvl_stop", 3, 2, 0, 1);

      // asynchronous reset mid-cycle, then release with up held
      #3;
      rst = 1'b1; up[0] = 1'b1;
      #1;
      chk("async_def", 0, 0, 0, 1);
      chk("async_sat", 1, 3, 0, 1);
      chk("async_clamp", 2, 2, 0, 1);
      chk("async_lvl", 3, 0, 0, 1);
      tick();
      rst = 1'b0;
      tick(); chk("post_rst_hold", 0, 0, 0, 1);
      up[0] = 1'b0; tick();
      up[0] = 1'b1; tick(); chk("post_rst_step", 0, 1, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/contador_mod_n_load.md
# contador_mod_n_load

Parametrised up/down counter with synchronous parallel load, a configurable count range [MIN, MAX], and selectable wrap or saturate behaviour at the limits. It is the successor to the fixed 0–15 counter and drives the display and control paths from push-button up/down requests. Optional rising-edge detection on `up` and `down` turns a held button into exactly one step. A registered terminal-count pulse lets counters be cascaded.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `MIN`, default 0: lowest count value; the reset value.
- `MAX`, default 15: highest count value; requires MIN < MAX ≤ 2^WIDTH−1.
- `SATURATE`, default 0: 0 = wrap at the limits; 1 = hold at the limits.
- `EDGE`, default 1: 1 = `up`/`down` act on rising edges only; 0 = level mode, one step per enabled cycle.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `EN` in 1: count enable; gates up/down steps only.
- `up` in 1: increment request.
- `down` in 1: decrement request.
- `load` in 1: synchronous parallel load.
- `din` in WIDTH: load value.
- `out` out WIDTH: current count, registered.
- `tc` out 1: terminal-count pulse, registered, one cycle wide.
- `dir` out 1: direction of the last step (1 = up, 0 = down), registered.

## Operation
- Reset (async, immediate): `out`=MIN, `tc`=0, `dir`=1. The internal `up_q`/`down_q` edge registers reset to 1, so an input held high across reset release does not cause a step.
- Step request per cycle:
  - EDGE=1: `up_req` = up & ~up_q, and likewise for down.
  - EDGE=0: `up_req` = up.
  - `up_q`/`down_q` sample the inputs every cycle regardless of EN or load. An edge that arrives while EN=0 is lost, not queued.
- Priority at each rising clk edge: load > (EN & step) > hold.
- Load:
  - `out` = din, clamped: din > MAX gives MAX; din < MIN gives MIN.
  - A load ignores EN and any step request in the same cycle.
  - `tc`=0; `dir` is unchanged.
- Step:
  - Requires EN=1 and exactly one of `up_req`/`down_req`.
  - Both requests at once: no change, `tc`=0.
  - Up below MAX: `out`+1. Down above MIN: `out`−1.
  - Up at MAX: SATURATE=0 gives `out`=MIN and `tc`=1; SATURATE=1 holds MAX and sets `tc`=1 (limit hit).
  - Down at MIN: mirror of the above (`out`=MAX, or hold at MIN), with `tc`=1.
  - Any accepted single-direction request sets `dir` (up→1, down→0), even when saturating.
- `tc` is 0 in every cycle without a limit event.
- Arithmetic:
  - All comparisons are unsigned at WIDTH bits.
  - +1/−1 are never applied past MAX/MIN, so there is no modular overflow inside [MIN, MAX].
  - `out` never leaves [MIN, MAX] after reset.

## Timing
- Latency:
  - EDGE=1: a request sampled at edge N with the input low at N−1 gives the new `out` after edge N, i.e. one cycle from the input rising to `out` changing.
  - EDGE=0: a step occurs at every edge where the input is high and EN=1.
  - `tc` and `dir` update on the same edge as `out`.
  - Load takes effect one edge after `load`=1 is sampled.
- Held inputs in EDGE=1 mode: exactly one step per low→high transition, however long the input stays high.
- Reset mid-operation: outputs go to their reset values without waiting for clk. The first edge after `rst` falls performs no step unless the input rose after release.
- All inputs are synchronous to `clk`; external buttons are synchronised upstream.

## Test plan
1. Reset and hold: `rst`=1, then release with `up` held high, EN=1, EDGE=1. Required: `out`=0, `tc`=0, `dir`=1 throughout; no step until `up` falls and rises again.
2. Wrap up, default parameters: step up 16 times with EN=1. Required: `out` runs 1…15 then 0; `tc`=1 only in the cycle `out` goes 15→0.
3. Saturate down, SATURATE=1, MIN=3, MAX=9: start at 3 and pulse `down` twice. Required: `out` stays 3, `tc`=1 for each pulse, `dir`=0.
4. Load clamp, MIN=2, MAX=12: `load`=1 with din=14, and `up` rising in the same cycle. Required: `out`=12, `tc`=0, `dir` unchanged; din=1 gives `out`=2.
5. Gating and conflicts: an `up` edge while EN=0 leaves `out` unchanged and is not replayed when EN returns to 1. With `up` and `down` rising together at EN=1, `out` does not change.
6. Level mode, EDGE=0: `up` held high for 5 cycles with EN=1 from 13, MAX=15, wrap. Required: `out` sequence 14, 15, 0, 1, 2, with a single `tc` pulse on the 15→0 step.
